// File: rtl/exe_stage_mdu_pkg.sv
// Shared types for the EXE stage: bus layouts, one-hot ALU op indices, mem_size and divider state encodings.
// Also holds the single-cycle combinational ALU used by the stage.
package exe_stage_mdu_pkg;
  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 12;
  localparam int LANES    = XLEN / 8;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4, OP_NOR = 5;
  localparam int OP_OR  = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9, OP_SRA = 10, OP_LUI = 11;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;

  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rj;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rkd;
    logic [ALU_OP_W-1:0] alu_op;
    logic                src1_is_pc;
    logic                src2_is_imm;
    logic                is_div;
    logic                div_signed;
    logic                div_rem;
    logic                mem_we;
    logic [1:0]          mem_size;
    logic                res_from_mem;
    logic                gr_we;
    logic [4:0]          dest;
    logic                res_until_mem;
  } id_exe_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            res_from_mem;
    logic [1:0]      mem_size;
    logic [1:0]      addr_lo;
    logic            ale;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic            res_until_mem;
    logic            fwd_valid;
    logic [XLEN-1:0] result;
    logic            gr_we;
    logic [4:0]      dest;
  } bypass_t;

  localparam int ID_EXE_W  = $bits(id_exe_t);
  localparam int EXE_MEM_W = $bits(exe_mem_t);

  // One-hot select: every op term is masked by its own opcode bit and OR-ed together.
  function automatic logic [XLEN-1:0] alu(input logic [ALU_OP_W-1:0] op,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [$clog2(XLEN)-1:0] sh;
    sh = b[$clog2(XLEN)-1:0];
    return ({XLEN{op[OP_ADD]}}  & (a + b))
         | ({XLEN{op[OP_SUB]}}  & (a - b))
         | ({XLEN{op[OP_SLT]}}  & {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)})
         | ({XLEN{op[OP_SLTU]}} & {{(XLEN-1){1'b0}}, a < b})
         | ({XLEN{op[OP_AND]}}  & (a & b))
         | ({XLEN{op[OP_NOR]}}  & ~(a | b))
         | ({XLEN{op[OP_OR]}}   & (a | b))
         | ({XLEN{op[OP_XOR]}}  & (a ^ b))
         | ({XLEN{op[OP_SLL]}}  & (a << sh))
         | ({XLEN{op[OP_SRL]}}  & (a >> sh))
         | ({XLEN{op[OP_SRA]}}  & $unsigned($signed(a) >>> sh))
         | ({XLEN{op[OP_LUI]}}  & b);
  endfunction
endpackage

// File: rtl/exe_stage_mdu_if.sv
// ID->EXE->MEM handshake, bypass and data SRAM bundle; master is the surrounding pipeline, slave is the EXE stage.
interface exe_stage_mdu_if;
  import exe_stage_mdu_pkg::*;
  logic                 id_to_exe_valid;
  logic                 exe_allow_in;
  id_exe_t              id_to_exe_bus;
  logic                 mem_allow_in;
  logic                 exe_to_mem_valid;
  exe_mem_t             exe_to_mem_bus;
  bypass_t              exe_to_id_bypass_bus;
  logic                 data_sram_en;
  logic [LANES-1:0]     data_sram_we;
  logic [XLEN-1:0]      data_sram_addr;
  logic [XLEN-1:0]      data_sram_wdata;

  modport master (output id_to_exe_valid, id_to_exe_bus, mem_allow_in,
                  input  exe_allow_in, exe_to_mem_valid, exe_to_mem_bus, exe_to_id_bypass_bus,
                         data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
  modport slave  (input  id_to_exe_valid, id_to_exe_bus, mem_allow_in,
                  output exe_allow_in, exe_to_mem_valid, exe_to_mem_bus, exe_to_id_bypass_bus,
                         data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/exe_stage_mdu_div_iter.sv
// Radix-2 restoring divider on operand magnitudes with signed fix-up; IDLE->BUSY(CYCLES)->DONE, held until ack.
// abort returns to IDLE from any state; result is stable for as long as DONE is held.
module exe_div_iter
  import exe_stage_mdu_pkg::*;
#(
  parameter int W      = 32,
  parameter int CYCLES = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic         ack,
  input  logic         sgn,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         done
);
  localparam int CW = $clog2(CYCLES) + 1;

  div_state_e  state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q, r, d, a_raw;
  logic          q_neg, r_neg, d_zero;
  logic [W-1:0]  a_abs, b_abs;
  logic [W:0]    r_sh;
  logic          under;

  assign a_abs = (sgn && dividend[W-1]) ? -dividend : dividend;
  assign b_abs = (sgn && divisor[W-1])  ? -divisor  : divisor;
  assign r_sh  = {r, q[W-1]};
  assign under = r_sh < {1'b0, d};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      a_raw  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      d_zero <= 1'b0;
    end else if (abort) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state  <= DIV_BUSY;
          cnt    <= '0;
          q      <= a_abs;
          r      <= '0;
          d      <= b_abs;
          a_raw  <= dividend;
          q_neg  <= sgn & (dividend[W-1] ^ divisor[W-1]);
          r_neg  <= sgn & dividend[W-1];
          d_zero <= (divisor == '0);
        end
        DIV_BUSY: begin
          // Extra cycles beyond W (if CYCLES > W) only count, they do not shift.
          if (cnt < CW'(W)) begin
            r <= under ? r_sh[W-1:0] : (r_sh[W-1:0] - d);
            q <= {q[W-2:0], ~under};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign quo  = d_zero ? '1    : (q_neg ? -q : q);
  assign rem  = d_zero ? a_raw : (r_neg ? -r : r);
  assign done = (state == DIV_DONE);
endmodule

// File: rtl/exe_stage_mdu.sv
// EXE stage: single-cycle ALU plus iterative divider that stalls via ready_go; store lane/alignment generation.
// Holds its result under MEM back-pressure; the SRAM is strobed only on the fire cycle, flush kills the stage.
module exe_stage_mdu
  import exe_stage_mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  exe_stage_mdu_if.slave io
);
  logic             exe_valid, ready_go, fire, div_done, mem_acc, ale;
  id_exe_t          ex;
  logic [XLEN-1:0]  src1, src2, alu_res, addr, result, div_quo, div_rmd, wdata;
  logic [1:0]       off;
  logic [LANES-1:0] lanes;
  exe_mem_t         mem_bus;
  bypass_t          byp;

  assign ready_go            = !ex.is_div || div_done;
  assign io.exe_allow_in     = !exe_valid || (ready_go && io.mem_allow_in);
  assign io.exe_to_mem_valid = exe_valid && ready_go && !flush;
  assign fire                = io.exe_to_mem_valid && io.mem_allow_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               exe_valid <= 1'b0;
    else if (flush)            exe_valid <= 1'b0;
    else if (io.exe_allow_in)  exe_valid <= io.id_to_exe_valid;
  end

  // Payload needs no reset: everything downstream is qualified by exe_valid.
  always_ff @(posedge clk) begin
    if (io.id_to_exe_valid && io.exe_allow_in) ex <= io.id_to_exe_bus;
  end

  exe_div_iter #(.W(XLEN), .CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (exe_valid && ex.is_div && !flush),
    .abort    (flush),
    .ack      (fire),
    .sgn      (ex.div_signed),
    .dividend (ex.rj),
    .divisor  (ex.rkd),
    .quo      (div_quo),
    .rem      (div_rmd),
    .done     (div_done)
  );

  assign src1    = ex.src1_is_pc  ? ex.pc  : ex.rj;
  assign src2    = ex.src2_is_imm ? ex.imm : ex.rkd;
  assign alu_res = alu(ex.alu_op, src1, src2);
  assign addr    = src1 + src2;
  assign off     = addr[1:0];
  assign result  = ex.is_div ? (ex.div_rem ? div_rmd : div_quo) : alu_res;
  assign mem_acc = ex.mem_we || ex.res_from_mem;
  assign ale     = mem_acc && (((ex.mem_size == MEM_SZ_H) && off[0]) ||
                               ((ex.mem_size == MEM_SZ_W) && (off != 2'b00)));

  always_comb begin
    lanes = '1;
    wdata = ex.rkd;
    case (ex.mem_size)
      MEM_SZ_B: begin lanes = LANES'(1) << off; wdata = {LANES{ex.rkd[7:0]}};        end
      MEM_SZ_H: begin lanes = LANES'(3) << off; wdata = {(LANES/2){ex.rkd[15:0]}};   end
      default:  begin lanes = '1;               wdata = ex.rkd;                      end
    endcase
  end

  assign io.data_sram_en    = fire && mem_acc && !ale;
  assign io.data_sram_we    = (io.data_sram_en && ex.mem_we) ? lanes : '0;
  assign io.data_sram_addr  = addr;
  assign io.data_sram_wdata = wdata;

  always_comb begin
    mem_bus              = '0;
    mem_bus.result       = result;
    mem_bus.res_from_mem = ex.res_from_mem;
    mem_bus.mem_size     = ex.mem_size;
    mem_bus.addr_lo      = off;
    mem_bus.ale          = ale;
    mem_bus.gr_we        = ex.gr_we;
    mem_bus.dest         = ex.dest;
    mem_bus.pc           = ex.pc;
    byp                  = '0;
    byp.res_until_mem    = ex.res_until_mem;
    byp.fwd_valid        = exe_valid && ex.gr_we && ready_go;
    byp.result           = result;
    byp.gr_we            = ex.gr_we;
    byp.dest             = ex.dest;
  end

  assign io.exe_to_mem_bus       = mem_bus;
  assign io.exe_to_id_bypass_bus = byp;
endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed + randomized bench for exe_stage_mdu against an arithmetic reference model.
module tb_exe_stage_mdu;
  import exe_stage_mdu_pkg::*;
  localparam int DIV_CYCLES = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exe_stage_mdu_if bus_if();
  exe_stage_mdu #(.DIV_CYCLES(DIV_CYCLES)) dut (.clk(clk), .resetn(resetn), .flush(flush), .io(bus_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input id_exe_t ins);
    bus_if.id_to_exe_valid = 1'b1;
    bus_if.id_to_exe_bus   = ins;
    tick();
    bus_if.id_to_exe_valid = 1'b0;
  endtask

  function automatic id_exe_t mk_alu(input int op, input logic [31:0] rj, input logic [31:0] rkd,
                                     input logic [31:0] imm, input logic use_imm, input logic use_pc);
    id_exe_t i;
    i = '0;
    i.pc = 32'h1c00_0000 + (rj & 32'hfffc);
    i.rj = rj; i.rkd = rkd; i.imm = imm;
    i.alu_op = 12'b1 << op;
    i.src2_is_imm = use_imm; i.src1_is_pc = use_pc;
    i.gr_we = 1'b1; i.dest = 5'd7;
    return i;
  endfunction

  function automatic id_exe_t mk_div(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b);
    id_exe_t i;
    i = mk_alu(OP_ADD, a, b, 32'h0, 1'b0, 1'b0);
    i.is_div = 1'b1; i.div_signed = sgn; i.div_rem = rem;
    return i;
  endfunction

  function automatic id_exe_t mk_mem(input logic st, input logic [1:0] size, input logic [31:0] base,
                                     input logic [31:0] ofs, input logic [31:0] data);
    id_exe_t i;
    i = mk_alu(OP_ADD, base, data, ofs, 1'b1, 1'b0);
    i.mem_we = st; i.res_from_mem = ~st; i.gr_we = ~st; i.mem_size = size;
    return i;
  endfunction

  // Reference model: plain arithmetic on the operands the instruction names.
  function automatic logic [31:0] exp_result(input id_exe_t i);
    logic [31:0] a, b, q, r;
    int op;
    a = i.src1_is_pc ? i.pc : i.rj;
    b = i.src2_is_imm ? i.imm : i.rkd;
    if (i.is_div) begin
      a = i.rj; b = i.rkd;
      if (b == 0) begin q = 32'hffff_ffff; r = a; end
      else if (i.div_signed && a == 32'h8000_0000 && b == 32'hffff_ffff) begin q = a; r = 0; end
      else if (i.div_signed) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
      return i.div_rem ? r : q;
    end
    op = 0;
    for (int k = 0; k < ALU_OP_W; k++) if (i.alu_op[k]) op = k;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      default: return b;
    endcase
  endfunction

  task automatic run_div(input string tag, input id_exe_t ins, input logic [31:0] exp);
    int n;
    issue(ins);
    chk({tag, "_fwd_busy"}, 32'(bus_if.exe_to_id_bypass_bus.fwd_valid), 32'd0);
    n = 0;
    while (!bus_if.exe_to_mem_valid && n < 200) begin tick(); n++; end
    chk({tag, "_stall"}, n, DIV_CYCLES + 1);
    chk({tag, "_res"}, bus_if.exe_to_mem_bus.result, exp);
  endtask

  initial begin
    id_exe_t ins;
    int pulses, sz, ofs;
    logic [31:0] base, dat, ad, exp_we, exp_wd, held;
    bus_if.id_to_exe_valid = 1'b0;
    bus_if.id_to_exe_bus   = '0;
    bus_if.mem_allow_in    = 1'b1;
    #12;
    chk("rst_valid", 32'(bus_if.exe_to_mem_valid), 32'd0);
    chk("rst_allow", 32'(bus_if.exe_allow_in), 32'd1);
    chk("rst_en",    32'(bus_if.data_sram_en), 32'd0);
    chk("rst_we",    32'(bus_if.data_sram_we), 32'd0);
    resetn = 1'b1;
    tick();

    ins = mk_alu(OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
    issue(ins);
    chk("add_valid", 32'(bus_if.exe_to_mem_valid), 32'd1);
    chk("add_res",   bus_if.exe_to_mem_bus.result, 32'd7);
    chk("add_allow", 32'(bus_if.exe_allow_in), 32'd1);
    chk("add_fwd",   32'(bus_if.exe_to_id_bypass_bus.fwd_valid), 32'd1);
    tick();
    chk("add_drain", 32'(bus_if.exe_to_mem_valid), 32'd0);

    for (int k = 0; k < 24; k++) begin
      ins = mk_alu($urandom_range(0, 11), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      issue(ins);
      chk("alu_rand_valid", 32'(bus_if.exe_to_mem_valid), 32'd1);
      chk("alu_rand_res", bus_if.exe_to_mem_bus.result, exp_result(ins));
    end
    tick();

    run_div("divw_m7_2",  mk_div(1'b1, 1'b0, 32'hffff_fff9, 32'd2), 32'hffff_fffd);
    run_div("modw_m7_2",  mk_div(1'b1, 1'b1, 32'hffff_fff9, 32'd2), 32'hffff_ffff);
    run_div("divwu_5_0",  mk_div(1'b0, 1'b0, 32'd5, 32'd0), 32'hffff_ffff);
    run_div("modwu_5_0",  mk_div(1'b0, 1'b1, 32'd5, 32'd0), 32'd5);
    run_div("divw_min",   mk_div(1'b1, 1'b0, 32'h8000_0000, 32'hffff_ffff), 32'h8000_0000);
    run_div("modw_min",   mk_div(1'b1, 1'b1, 32'h8000_0000, 32'hffff_ffff), 32'd0);
    for (int k = 0; k < 8; k++) begin
      ins = mk_div(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28)));
      run_div("div_rand", ins, exp_result(ins));
    end

    // DONE held under back-pressure, then fire while loading the next instruction.
    ins = mk_div(1'b0, 1'b0, 32'd1000, 32'd7);
    run_div("div_bp", ins, 32'd142);
    bus_if.mem_allow_in = 1'b0;
    held = exp_result(ins);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("div_bp_hold_valid", 32'(bus_if.exe_to_mem_valid), 32'd1);
      chk("div_bp_hold_res", bus_if.exe_to_mem_bus.result, held);
    end
    bus_if.mem_allow_in = 1'b1;
    #1;
    chk("div_done_allow", 32'(bus_if.exe_allow_in), 32'd1);
    issue(mk_alu(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0));
    chk("after_div_res", bus_if.exe_to_mem_bus.result, 32'd30);
    tick();

    issue(mk_mem(1'b1, MEM_SZ_B, 32'h1000, 32'd3, 32'h0000_00ab));
    chk("stb_en",    32'(bus_if.data_sram_en), 32'd1);
    chk("stb_we",    32'(bus_if.data_sram_we), 32'h8);
    chk("stb_wdata", bus_if.data_sram_wdata, 32'habab_abab);
    chk("stb_addr",  bus_if.data_sram_addr, 32'h1003);
    tick();
    chk("stb_en_once", 32'(bus_if.data_sram_en), 32'd0);

    issue(mk_mem(1'b1, MEM_SZ_H, 32'h1000, 32'd1, 32'h1234_5678));
    chk("sth_ale", 32'(bus_if.exe_to_mem_bus.ale), 32'd1);
    chk("sth_en",  32'(bus_if.data_sram_en), 32'd0);
    chk("sth_we",  32'(bus_if.data_sram_we), 32'd0);
    tick();

    for (int k = 0; k < 10; k++) begin
      sz = $urandom_range(0, 2); base = $urandom; ofs = $urandom_range(0, 15); dat = $urandom;
      ad = base + 32'(ofs);
      exp_wd = (sz == 0) ? dat[7:0] * 32'h0101_0101 : (sz == 1) ? dat[15:0] * 32'h0001_0001 : dat;
      exp_we = ((ad % (32'd1 << sz)) != 0) ? 32'd0 : (((32'd1 << (32'd1 << sz)) - 1) << (ad % 4));
      issue(mk_mem(1'b1, 2'(sz), base, 32'(ofs), dat));
      chk("st_rand_we", 32'(bus_if.data_sram_we), exp_we);
      chk("st_rand_en", 32'(bus_if.data_sram_en), (exp_we != 0) ? 32'd1 : 32'd0);
      if (exp_we != 0) chk("st_rand_wdata", bus_if.data_sram_wdata, exp_wd);
    end
    tick();

    bus_if.mem_allow_in = 1'b0;
    issue(mk_mem(1'b0, MEM_SZ_W, 32'h2000, 32'd4, 32'd0));
    pulses = 0;
    for (int k = 0; k < 3; k++) begin pulses += int'(bus_if.data_sram_en); tick(); end
    bus_if.mem_allow_in = 1'b1;
    #1;
    chk("ldw_en_fire", 32'(bus_if.data_sram_en), 32'd1);
    chk("ldw_we", 32'(bus_if.data_sram_we), 32'd0);
    pulses += int'(bus_if.data_sram_en);
    tick();
    pulses += int'(bus_if.data_sram_en);
    chk("ldw_pulses", pulses, 1);

    ins = mk_div(1'b0, 1'b0, 32'd100, 32'd7);
    issue(ins);
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1;
    #1;
    chk("flush_valid_now", 32'(bus_if.exe_to_mem_valid), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid_next", 32'(bus_if.exe_to_mem_valid), 32'd0);
    chk("flush_allow", 32'(bus_if.exe_allow_in), 32'd1);
    run_div("div_restart", mk_div(1'b1, 1'b0, 32'hffff_ff9c, 32'd7), 32'hffff_fff2);
    tick();

    issue(mk_mem(1'b1, MEM_SZ_W, 32'h3000, 32'd0, 32'hdead_beef));
    flush = 1'b1;
    #1;
    chk("flush_fire_en", 32'(bus_if.data_sram_en), 32'd0);
    chk("flush_fire_valid", 32'(bus_if.exe_to_mem_valid), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_fire_killed", 32'(bus_if.exe_to_mem_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
